// File: rtl/ising_pkt_decoder_pkg.sv
// Shared packet type codes, opcodes, field positions and sequencer states.
// No logic, constants and types only.
// Imported by the decoder, its interface users and the instruction FIFO.
package ising_pkt_pkg;

  // Packet type codes carried in pkt[31:29]
  localparam logic [2:0] PKT_IDLE = 3'd0;
  localparam logic [2:0] PKT_INST = 3'd1;
  localparam logic [2:0] PKT_PARA = 3'd2;
  localparam logic [2:0] PKT_SPIN = 3'd4;
  localparam logic [2:0] PKT_UART = 3'd7;

  // Opcodes carried in pkt[28:23]
  localparam logic [5:0] OP_FMSIG = 6'h01;
  localparam logic [5:0] OP_FJSIG = 6'h02;
  localparam logic [5:0] SET_T    = 6'h04;
  localparam logic [5:0] SET_CK   = 6'h05;
  localparam logic [5:0] SET_PK   = 6'h06;

  // Field bit positions
  localparam int TYPE_MSB   = 31;
  localparam int TYPE_LSB   = 29;
  localparam int OP_MSB     = 28;
  localparam int OP_LSB     = 23;
  localparam int FLAGS_MSB  = 22;  // {flip, first, up, lr}
  localparam int FLAGS_LSB  = 19;
  localparam int VAL_MSB    = 15;  // instruction addr / parameter value
  localparam int VAL_LSB    = 0;
  localparam int SNUM_MSB   = 23;
  localparam int SNUM_LSB   = 17;
  localparam int SIDX_MSB   = 16;
  localparam int SIDX_LSB   = 1;
  localparam int SSTATE_BIT = 0;

  // Parameter sequencer states
  typedef enum logic [1:0] {
    S_WAIT_T  = 2'd0,
    S_WAIT_PK = 2'd1,
    S_WAIT_CK = 2'd2,
    S_READY   = 2'd3
  } seq_state_t;

  // One queued instruction toward the PE array (26 bits)
  typedef struct packed {
    logic [5:0]  opcode;
    logic [3:0]  flags;
    logic [15:0] addr;
  } inst_t;

endpackage

// File: rtl/ising_pkt_decoder_if.sv
// Ready/valid instruction channel from the decoder to the spin PE array.
// No storage; latency is that of the producer.
// Head is held while valid && !ready; consumer pops with ready.
interface ising_pkt_decoder_if;
  logic        valid;
  logic        ready;
  logic [5:0]  opcode;
  logic [3:0]  flags;
  logic [15:0] addr;

  modport master (output valid, output opcode, output flags, output addr, input ready);
  modport slave  (input valid, input opcode, input flags, input addr, output ready);
endinterface

// File: rtl/ising_pkt_decoder_fifo.sv
// First-word-fall-through instruction FIFO with occupancy count.
// Write to an empty FIFO is visible on the head one edge later.
// Push ignored when full (a same-cycle pop does not make room); pop ignored when empty.
module ising_inst_fifo
  import ising_pkt_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  inst_t         push_dat,
  input  logic          pop,
  output inst_t         head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  inst_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head forced to zero when empty so stale storage never leaks out
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ising_pkt_decoder.sv
// Decodes the controller packet stream into parameter regs, an instruction FIFO and a spin-load port.
// Registers/strobes update one edge after the packet; instruction head appears one edge after push.
// Input has no backpressure: instructions arriving at a full FIFO are dropped and flagged.
module ising_pkt_decoder
  import ising_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pkt_in,
  ising_pkt_decoder_if.master  ins,
  output logic [15:0]          t_reg,
  output logic [15:0]          pk_reg,
  output logic [15:0]          ck_reg,
  output logic                 params_ready,
  output logic [CNT_W-1:0]     round_cnt,
  output logic                 spin_we,
  output logic [6:0]           spin_num,
  output logic [15:0]          spin_index,
  output logic                 spin_state,
  output logic                 ovf_err,
  output logic                 seq_err,
  output logic                 bad_pkt
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]     pkt_type;
  logic [5:0]     pkt_op;
  logic [15:0]    pkt_val;
  logic           is_inst;
  logic           is_para;
  logic           is_spin;
  logic           is_bad;
  logic           ins_room;
  inst_t          push_dat;
  inst_t          head_dat;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_cnt;
  seq_state_t     state;

  assign pkt_type = pkt_in[TYPE_MSB:TYPE_LSB];
  assign pkt_op   = pkt_in[OP_MSB:OP_LSB];
  assign pkt_val  = pkt_in[VAL_MSB:VAL_LSB];

  assign is_inst  = (pkt_type == PKT_INST);
  assign is_para  = (pkt_type == PKT_PARA);
  assign is_spin  = (pkt_type == PKT_SPIN);
  // Idle and UART-return types fall through silently; everything else unknown is reserved
  assign is_bad   = !(pkt_type inside {PKT_IDLE, PKT_INST, PKT_PARA, PKT_SPIN, PKT_UART});

  // Room is judged on start-of-cycle occupancy, so a concurrent pop never admits a push
  assign ins_room = (fifo_cnt < FCW'(FIFO_DEPTH));

  assign push_dat.opcode = pkt_op;
  assign push_dat.flags  = pkt_in[FLAGS_MSB:FLAGS_LSB];
  assign push_dat.addr   = pkt_val;

  ising_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (is_inst && ins_room),
    .push_dat (push_dat),
    .pop      (ins.valid && ins.ready),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign ins.valid  = !fifo_empty;
  assign ins.opcode = head_dat.opcode;
  assign ins.flags  = head_dat.flags;
  assign ins.addr   = head_dat.addr;

  // Parameter sequencer with its registers, round counter and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_WAIT_T;
      params_ready <= 1'b0;
      t_reg        <= '0;
      pk_reg       <= '0;
      ck_reg       <= '0;
      round_cnt    <= '0;
      ovf_err      <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      if (is_inst) begin
        if (fifo_full)     ovf_err <= 1'b1;
        if (!params_ready) seq_err <= 1'b1;
      end
      if (is_para) begin
        case (pkt_op)
          SET_T: begin
            t_reg <= pkt_val;
            if (state == S_WAIT_T || state == S_READY) begin
              state        <= S_WAIT_PK;
              params_ready <= 1'b0;
            end else begin
              seq_err <= 1'b1;
            end
          end
          SET_PK: begin
            pk_reg <= pkt_val;
            if (state == S_WAIT_PK) state <= S_WAIT_CK;
            else                    seq_err <= 1'b1;
          end
          SET_CK: begin
            ck_reg <= pkt_val;
            if (state == S_WAIT_CK) begin
              state        <= S_READY;
              params_ready <= 1'b1;
              round_cnt    <= round_cnt + 1'b1;
            end else begin
              seq_err <= 1'b1;
            end
          end
          default: seq_err <= 1'b1;
        endcase
      end
    end
  end

  // Spin-load strobe and reserved-type pulse; spin fields hold between loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spin_we    <= 1'b0;
      spin_num   <= '0;
      spin_index <= '0;
      spin_state <= 1'b0;
      bad_pkt    <= 1'b0;
    end else begin
      spin_we <= is_spin;
      bad_pkt <= is_bad;
      if (is_spin) begin
        spin_num   <= pkt_in[SNUM_MSB:SNUM_LSB];
        spin_index <= pkt_in[SIDX_MSB:SIDX_LSB];
        spin_state <= pkt_in[SSTATE_BIT];
      end
    end
  end

endmodule

// File: tb/tb_ising_pkt_decoder.sv
// Directed bench for ising_pkt_decoder: params, instruction FIFO, spin load, errors, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point too.
// PE-side ready is driven directly per scenario.
module tb_ising_pkt_decoder;
  import ising_pkt_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pkt_in;
  logic [15:0] t_reg, pk_reg, ck_reg;
  logic        params_ready;
  logic [15:0] round_cnt;
  logic        spin_we;
  logic [6:0]  spin_num;
  logic [15:0] spin_index;
  logic        spin_state;
  logic        ovf_err, seq_err, bad_pkt;

  int checks   = 0;
  int failures = 0;

  ising_pkt_decoder_if ins_if ();

  ising_pkt_decoder #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_in       (pkt_in),
    .ins          (ins_if),
    .t_reg        (t_reg),
    .pk_reg       (pk_reg),
    .ck_reg       (ck_reg),
    .params_ready (params_ready),
    .round_cnt    (round_cnt),
    .spin_we      (spin_we),
    .spin_num     (spin_num),
    .spin_index   (spin_index),
    .spin_state   (spin_state),
    .ovf_err      (ovf_err),
    .seq_err      (seq_err),
    .bad_pkt      (bad_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_para(input logic [5:0] op, input logic [15:0] v);
    return {3'd2, op, 7'd0, v};
  endfunction

  function automatic logic [31:0] mk_inst(input logic [5:0] op, input logic [3:0] fl, input logic [15:0] a);
    return {3'd1, op, fl, 3'd0, a};
  endfunction

  function automatic logic [31:0] mk_spin(input logic [6:0] n, input logic [15:0] idx, input logic st);
    return {3'd4, 5'd0, n, idx, st};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    pkt_in = '0;
    ins_if.ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_params(input logic [15:0] t, input logic [15:0] pk, input logic [15:0] ck);
    pkt_in = mk_para(SET_T, t);  tick();
    pkt_in = mk_para(SET_PK, pk); tick();
    pkt_in = mk_para(SET_CK, ck); tick();
    pkt_in = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pkt_in = '0;
    ins_if.ready = 1'b0;
    #1;
    checks++;
    if ({ins_if.valid, t_reg, pk_reg, ck_reg, params_ready, round_cnt, spin_we, ovf_err, seq_err, bad_pkt} !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b t=%h pk=%h ck=%h rdy=%b rc=%0d we=%b ovf=%b seq=%b bad=%b, all required 0",
               ins_if.valid, t_reg, pk_reg, ck_reg, params_ready, round_cnt, spin_we, ovf_err, seq_err, bad_pkt);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_params_in_order;
    pkt_in = mk_para(SET_T, 16'h3C00); tick();
    checks++;
    if (t_reg !== 16'h3C00 || params_ready !== 1'b0) begin
      failures++; $display("FAIL param_t: t=%h rdy=%b, required 3c00 0", t_reg, params_ready);
    end
    pkt_in = mk_para(SET_PK, 16'h9019); tick();
    pkt_in = mk_para(SET_CK, 16'h1419); tick();
    pkt_in = '0;
    checks++;
    if (pk_reg !== 16'h9019 || ck_reg !== 16'h1419 || params_ready !== 1'b1 || round_cnt !== 16'd1 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL param_set: pk=%h ck=%h rdy=%b rc=%0d seq=%b, required 9019 1419 1 1 0",
               pk_reg, ck_reg, params_ready, round_cnt, seq_err);
    end
  endtask

  task automatic test_inst_flow;
    ins_if.ready = 1'b1;
    pkt_in = mk_inst(6'd2, 4'b0101, 16'h0007);
    #1;
    checks++;
    if (ins_if.valid !== 1'b0) begin
      failures++; $display("FAIL inst_pre: valid=%b, required 0", ins_if.valid);
    end
    tick();
    pkt_in = '0;
    checks++;
    if (ins_if.valid !== 1'b1 || ins_if.opcode !== 6'd2 || ins_if.flags !== 4'b0101 || ins_if.addr !== 16'h0007) begin
      failures++;
      $display("FAIL inst_head: valid=%b op=%h fl=%b addr=%h, required 1 02 0101 0007",
               ins_if.valid, ins_if.opcode, ins_if.flags, ins_if.addr);
    end
    tick();
    checks++;
    if (ins_if.valid !== 1'b0 || ovf_err !== 1'b0 || seq_err !== 1'b0) begin
      failures++; $display("FAIL inst_pop: valid=%b ovf=%b seq=%b, required 0 0 0", ins_if.valid, ovf_err, seq_err);
    end
  endtask

  task automatic test_back_to_back;
    ins_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pkt_in = mk_inst(6'd1, 4'b0000, 16'(10 + i));
      tick();
      checks++;
      if (ins_if.valid !== 1'b1 || ins_if.addr !== 16'(10 + i)) begin
        failures++; $display("FAIL b2b_head%0d: valid=%b addr=%0d, required 1 %0d", i, ins_if.valid, ins_if.addr, 10 + i);
      end
    end
    pkt_in = '0;
    tick();
    checks++;
    if (ins_if.valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain: valid=%b, required 0", ins_if.valid);
    end
  endtask

  task automatic test_overflow;
    ins_if.ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      pkt_in = mk_inst(6'd1, 4'b0000, 16'(i));
      tick();
    end
    pkt_in = '0;
    checks++;
    if (ovf_err !== 1'b1 || ins_if.valid !== 1'b1) begin
      failures++; $display("FAIL ovf_flag: ovf=%b valid=%b, required 1 1", ovf_err, ins_if.valid);
    end
    ins_if.ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (ins_if.valid !== 1'b1 || ins_if.addr !== 16'(i)) begin
        failures++; $display("FAIL ovf_drain%0d: valid=%b addr=%0d, required 1 %0d", i, ins_if.valid, ins_if.addr, i);
      end
      tick();
    end
    checks++;
    if (ins_if.valid !== 1'b0) begin
      failures++; $display("FAIL ovf_empty: valid=%b, required 0", ins_if.valid);
    end
  endtask

  task automatic test_full_pop_no_room;
    do_reset();
    send_params(16'h0001, 16'h0002, 16'h0003);
    for (int i = 1; i <= 16; i++) begin
      pkt_in = mk_inst(6'd1, 4'b0000, 16'(i));
      tick();
    end
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++; $display("FAIL full16_no_ovf: ovf=%b, required 0", ovf_err);
    end
    // Push while full and popping in the same cycle: must still drop
    ins_if.ready = 1'b1;
    pkt_in = mk_inst(6'd1, 4'b0000, 16'd99);
    tick();
    pkt_in = '0;
    checks++;
    if (ovf_err !== 1'b1) begin
      failures++; $display("FAIL full_pop_ovf: ovf=%b, required 1", ovf_err);
    end
    for (int i = 2; i <= 16; i++) begin
      checks++;
      if (ins_if.valid !== 1'b1 || ins_if.addr !== 16'(i)) begin
        failures++; $display("FAIL full_pop_drain%0d: valid=%b addr=%0d, required 1 %0d", i, ins_if.valid, ins_if.addr, i);
      end
      tick();
    end
    checks++;
    if (ins_if.valid !== 1'b0) begin
      failures++; $display("FAIL full_pop_empty: valid=%b addr=%0d, required 0", ins_if.valid, ins_if.addr);
    end
  endtask

  task automatic test_seq_error;
    do_reset();
    pkt_in = mk_para(SET_PK, 16'h1234);
    tick();
    pkt_in = '0;
    checks++;
    if (pk_reg !== 16'h1234 || seq_err !== 1'b1 || params_ready !== 1'b0) begin
      failures++; $display("FAIL seq_pk_first: pk=%h seq=%b rdy=%b, required 1234 1 0", pk_reg, seq_err, params_ready);
    end
    // State must still be waiting for T: a full in-order set completes normally
    send_params(16'h1111, 16'h2222, 16'h3333);
    checks++;
    if (params_ready !== 1'b1 || round_cnt !== 16'd1 || pk_reg !== 16'h2222) begin
      failures++; $display("FAIL seq_recover: rdy=%b rc=%0d pk=%h, required 1 1 2222", params_ready, round_cnt, pk_reg);
    end
    pkt_in = mk_para(6'h07, 16'hFFFF);
    tick();
    pkt_in = '0;
    checks++;
    if (t_reg !== 16'h1111 || pk_reg !== 16'h2222 || ck_reg !== 16'h3333 || params_ready !== 1'b1) begin
      failures++; $display("FAIL seq_bad_op: t=%h pk=%h ck=%h rdy=%b, required 1111 2222 3333 1", t_reg, pk_reg, ck_reg, params_ready);
    end
  endtask

  task automatic test_inst_before_params;
    do_reset();
    pkt_in = mk_inst(6'd3, 4'b1000, 16'h00AA);
    tick();
    pkt_in = '0;
    checks++;
    if (seq_err !== 1'b1 || ins_if.valid !== 1'b1 || ins_if.addr !== 16'h00AA || ins_if.flags !== 4'b1000) begin
      failures++;
      $display("FAIL inst_early: seq=%b valid=%b addr=%h fl=%b, required 1 1 00aa 1000", seq_err, ins_if.valid, ins_if.addr, ins_if.flags);
    end
  endtask

  task automatic test_spin_and_types;
    logic [15:0] t_hold;
    logic        valid_hold;
    pkt_in = mk_spin(7'd63, 16'h0102, 1'b1);
    tick();
    pkt_in = '0;
    checks++;
    if (spin_we !== 1'b1 || spin_num !== 7'd63 || spin_index !== 16'h0102 || spin_state !== 1'b1) begin
      failures++;
      $display("FAIL spin_load: we=%b num=%0d idx=%h st=%b, required 1 63 0102 1", spin_we, spin_num, spin_index, spin_state);
    end
    tick();
    checks++;
    if (spin_we !== 1'b0 || spin_num !== 7'd63 || spin_index !== 16'h0102 || spin_state !== 1'b1) begin
      failures++;
      $display("FAIL spin_hold: we=%b num=%0d idx=%h st=%b, required 0 63 0102 1", spin_we, spin_num, spin_index, spin_state);
    end
    for (int k = 0; k < 3; k++) begin
      logic [2:0] ty;
      ty = (k == 0) ? 3'd5 : (k == 1) ? 3'd3 : 3'd6;
      pkt_in = {ty, 29'h1ABCDEF};
      tick();
      pkt_in = '0;
      checks++;
      if (bad_pkt !== 1'b1) begin
        failures++; $display("FAIL bad_pulse_t%0d: bad=%b, required 1", ty, bad_pkt);
      end
      tick();
      checks++;
      if (bad_pkt !== 1'b0) begin
        failures++; $display("FAIL bad_clear_t%0d: bad=%b, required 0", ty, bad_pkt);
      end
    end
    t_hold = t_reg;
    valid_hold = ins_if.valid;
    pkt_in = {3'd7, 29'h1FFFFFFF};
    tick();
    pkt_in = '0;
    checks++;
    if (bad_pkt !== 1'b0 || spin_we !== 1'b0 || t_reg !== t_hold || ins_if.valid !== valid_hold || spin_index !== 16'h0102) begin
      failures++;
      $display("FAIL uart_ignore: bad=%b we=%b t=%h valid=%b idx=%h, required 0 0 %h %b 0102",
               bad_pkt, spin_we, t_reg, ins_if.valid, spin_index, t_hold, valid_hold);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    pkt_in = mk_inst(6'd1, 4'b0000, 16'd1); tick();
    pkt_in = mk_inst(6'd1, 4'b0000, 16'd2); tick();
    send_params(16'h3C00, 16'h9019, 16'h1419);
    for (int i = 3; i <= 5; i++) begin
      pkt_in = mk_inst(6'd1, 4'b0000, 16'(i));
      tick();
    end
    pkt_in = '0;
    checks++;
    if (ins_if.valid !== 1'b1 || seq_err !== 1'b1 || t_reg !== 16'h3C00 || params_ready !== 1'b1) begin
      failures++; $display("FAIL arst_setup: valid=%b seq=%b t=%h rdy=%b, required 1 1 3c00 1", ins_if.valid, seq_err, t_reg, params_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ins_if.valid, ins_if.addr, t_reg, pk_reg, ck_reg, params_ready, round_cnt, ovf_err, seq_err, bad_pkt, spin_we} !== '0) begin
      failures++;
      $display("FAIL arst_clear: valid=%b addr=%h t=%h pk=%h ck=%h rdy=%b rc=%0d ovf=%b seq=%b, all required 0",
               ins_if.valid, ins_if.addr, t_reg, pk_reg, ck_reg, params_ready, round_cnt, ovf_err, seq_err);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ins_if.valid !== 1'b0 || params_ready !== 1'b0) begin
      failures++; $display("FAIL arst_after: valid=%b rdy=%b, required 0 0", ins_if.valid, params_ready);
    end
  endtask

  initial begin
    test_reset();
    test_params_in_order();
    test_inst_flow();
    test_back_to_back();
    test_overflow();
    test_full_pop_no_room();
    test_seq_error();
    test_inst_before_params();
    test_spin_and_types();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ising_pkt_decoder.md
Name: ising_pkt_decoder

Overview:
- Downstream neighbour of the annealing top-level controller. Consumes its 32-bit `data_pkt` stream, one packet per clock, no backpressure.
- Decodes each packet by its 3-bit type header into three outputs:
  - annealing parameter registers (T, PK, CK);
  - a buffered, ready/valid instruction stream toward the spin PE array;
  - a one-cycle spin-load write port.
- Also checks parameter sequencing and flags overflow and protocol errors.

Parameters:
- FIFO_DEPTH, 16, instruction FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the round counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pkt_in  in  32  controller packet: [31:29] type; type 0 = idle.
- ins_valid  out  1  FIFO head is valid.
- ins_ready  in  1  PE array accepts the head.
- ins_opcode  out  6  head opcode.
- ins_flags  out  4  head {flip, first, up, lr}.
- ins_addr  out  16  head on-chip address.
- t_reg / pk_reg / ck_reg  out  16 each  latched FP16 parameters.
- params_ready  out  1  a complete T→PK→CK set is held.
- round_cnt  out  CNT_W  count of completed parameter sets.
- spin_we  out  1  spin-load strobe.
- spin_num  out  7  spins in current block.
- spin_index  out  16  spin index.
- spin_state  out  1  spin value.
- ovf_err  out  1  sticky: an instruction was dropped because the FIFO was full.
- seq_err  out  1  sticky: protocol-order violation.
- bad_pkt  out  1  one-cycle pulse on a reserved type.

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO emptied, sequencer in S_WAIT_T.
- Type 1 (instruction), field layout:
  - [28:23] opcode; [22] flip; [21] first; [20] up; [19] lr; [18:16] ignored; [15:0] addr.
  - Pushed as {opcode, flags, addr}, 26 bits.
  - Push occurs iff the FIFO occupancy at the start of the cycle is < FIFO_DEPTH. A pop in the same cycle does not free space for that push.
  - Otherwise the packet is dropped and ovf_err sets.
- FIFO output:
  - First-word-fall-through: ins_valid = !empty, and the head fields are driven combinationally from storage.
  - Pop when ins_valid && ins_ready.
  - A packet written into an empty FIFO at edge n is visible on the outputs after edge n (1-cycle latency).
  - Simultaneous push and pop when not full: occupancy unchanged.
- Type 2 (parameter), field layout: [28:23] opcode, [15:0] value; the register updates at the next edge.
  - Opcode 6'h04 (SET_T) writes t_reg; 6'h06 (SET_PK) writes pk_reg; 6'h05 (SET_CK) writes ck_reg.
  - Any other opcode: no register write, and seq_err sets.
- Parameter sequencer states: S_WAIT_T, S_WAIT_PK, S_WAIT_CK, S_READY.
  - SET_T: from S_WAIT_T or S_READY → S_WAIT_PK.
  - SET_PK: from S_WAIT_PK → S_WAIT_CK.
  - SET_CK: from S_WAIT_CK → S_READY, and round_cnt increments (wraps modulo 2^CNT_W).
  - Out-of-order SET (any other combination): the register is still written, the state is unchanged, and seq_err sets.
  - params_ready = (state == S_READY), driven from a register.
- Type 1 arriving while params_ready=0: seq_err sets, but the packet is still pushed (subject to the full rule).
- Type 4 (spin load), field layout: [23:17] num, [16:1] index, [0] state.
  - Registered: spin_we=1 for exactly one cycle after the packet edge, with the fields valid alongside.
  - Otherwise spin_we=0 and the fields hold their last values.
- Type 7 (UART return path): ignored silently.
- Types 3, 5, 6: bad_pkt pulses for one cycle; no other effect.
- Sticky errors clear only on rst.
- Reset mid-operation: the FIFO contents are discarded and the parameter registers return to 0; no partial packet state survives.

Decomposition:
- Package ising_pkt_pkg holds:
  - type codes PKT_IDLE=0, PKT_INST=1, PKT_PARA=2, PKT_SPIN=4, PKT_UART=7;
  - opcodes OP_FMSIG=1, OP_FJSIG=2, SET_T=4, SET_CK=5, SET_PK=6;
  - field bit-position constants;
  - the sequencer state enum.
- One sub-module, ising_inst_fifo: 26-bit FWFT synchronous FIFO with async reset, full/empty flags and occupancy count.

Test Plan:
1. Params in order: type2 SET_T 0x3C00, SET_PK 0x9019, SET_CK 0x1419 on consecutive cycles → registers match, params_ready=1 from the cycle after SET_CK, round_cnt=1, seq_err=0.
2. Instruction flow: after test 1, type1 opcode 2, flags 4'b0101, addr 0x0007, with ins_ready=1 → ins_valid high one cycle later with matching fields, then low; ovf_err=0.
3. Overflow: ins_ready=0, 17 type1 packets with addr 1..17 (FIFO_DEPTH=16) → ovf_err=1; release ins_ready → exactly addrs 1..16 pop in order.
4. Sequence error: SET_PK 0x1234 from reset → pk_reg=0x1234, state stays S_WAIT_T, seq_err=1, params_ready=0.
5. Spin load: type4 num=63, index=0x0102, state=1 → spin_we single pulse with those fields. Type 5 packet → bad_pkt one pulse. Type 7 → no output change.
6. Async reset mid-burst: assert rst between clock edges with 5 entries queued → ins_valid, all registers and errors 0 immediately, before the next edge.
